dcache_line_mover: RTL



---
 rtl/dcache_line_mover.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dcache_line_mover.sv
// dcache_line_mover: sequences one cache line of fills or evicts through the
// data store SRAM port. It hides the store's one-cycle registered read latency
// so that evicts sustain one word per cycle.
module dcache_line_mover #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_WORDS      = 256,
  parameter int unsigned WORDS_PER_LINE = 4,
  localparam int unsigned AW = $clog2(NUM_WORDS),
  localparam int unsigned OW = $clog2(WORDS_PER_LINE),
  localparam int unsigned LW = AW - OW,
  localparam int unsigned BW = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_fill_i,
  input  logic [LW-1:0]         req_line_i,
  input  logic                  fill_valid_i,
  output logic                  fill_ready_o,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  output logic                  evict_valid_o,
  input  logic                  evict_ready_i,
  output logic [DATA_WIDTH-1:0] evict_data_o,
  output logic                  done_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [BW-1:0]         sram_be_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  typedef enum logic [1:0] {IDLE, FILL, EV_RD, EV_OUT} state_e;

  localparam logic [OW-1:0] LAST = OW'(WORDS_PER_LINE - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] line_q, line_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [OW-1:0] addr_off;

  // Data moves straight through; only the control path is sequenced here.
  assign sram_wdata_o = fill_data_i;
  assign evict_data_o = sram_rdata_i;
  assign done_o       = done_q;
  // The word offset is the current count, except on an evict advance where
  // the read must target the next word so its data lands as it is presented.
  assign sram_addr_o  = {line_q, addr_off};

  // State, line, word counter and done pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counter updates and SRAM/handshake strobes.
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    addr_off      = cnt_q;
    req_ready_o   = 1'b0;
    fill_ready_o  = 1'b0;
    evict_valid_o = 1'b0;
    sram_en_o     = 1'b0;
    sram_we_o     = 1'b0;
    sram_be_o     = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          line_d  = req_line_i;
          cnt_d   = '0;
          state_d = req_fill_i ? FILL : EV_RD;
        end
      end
      FILL: begin
        fill_ready_o = 1'b1;
        if (fill_valid_i) begin
          sram_en_o = 1'b1;
          sram_we_o = 1'b1;
          sram_be_o = '1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      EV_RD: begin
        // Prime the read pipeline with word 0 of the line.
        sram_en_o = 1'b1;
        state_d   = EV_OUT;
      end
      EV_OUT: begin
        evict_valid_o = 1'b1;
        // Stalls issue no read, so the SRAM output register holds the word.
        if (evict_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            sram_en_o = 1'b1;
            addr_off  = cnt_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
